fetch_unit: RTL

Instruction fetch stage of the RISC-V core. It holds the program counter and issues single-outstanding requests to instruction memory. Returned instruction words land in the IF/ID register, whose opcode field drives the `control` decoder directly. The block absorbs decode stalls through a one-entry skid buffer and accepts PC redirects from branch/jump resolution.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/fetch_skid_buf.sv | 46 ++++
 rtl/fetch_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, canonical NOP, base opcodes
// and the instruction-fetch state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } fetch_state_t;

  // Opcode field of an instruction word.
  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding register that parks a fetched word while
// decode is stalled.
module fetch_skid_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);

  logic            valid_r;
  logic [XLEN-1:0] pc_r;
  logic [31:0]     instr_r;

  // Entry register; clear wins over load so a redirect always empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      pc_r    <= {XLEN{1'b0}};
      instr_r <= 32'h0000_0000;
    end else if (clear) begin
      valid_r <= 1'b0;
      pc_r    <= {XLEN{1'b0}};
      instr_r <= 32'h0000_0000;
    end else if (load) begin
      valid_r <= 1'b1;
      pc_r    <= load_pc;
      instr_r <= load_instr;
    end else begin
      valid_r <= valid_r;
      pc_r    <= pc_r;
      instr_r <= instr_r;
    end
  end

  assign valid = valid_r;
  assign pc    = pc_r;
  assign instr = instr_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem requests, IF/ID
// register with a one-entry skid buffer, and branch/jump redirects.
module fetch_unit #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            id_stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic [6:0]      if_opcode
);

  import riscv_pkg::*;

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(32'd4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(32'd3);

  fetch_state_t    state_r, state_n;
  logic [XLEN-1:0] pc_r, pc_n;
  logic [XLEN-1:0] pc_req_r, pc_req_n;
  logic            if_valid_r, if_valid_n;
  logic [XLEN-1:0] if_pc_r, if_pc_n;
  logic [31:0]     if_instr_r, if_instr_n;

  logic            accept_s;
  logic            skid_load_s;
  logic            skid_clear_s;
  logic            skid_valid_s;
  logic [XLEN-1:0] skid_pc_s;
  logic [31:0]     skid_instr_s;

  fetch_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load_s),
    .clear      (skid_clear_s),
    .load_pc    (pc_req_r),
    .load_instr (imem_rdata),
    .valid      (skid_valid_s),
    .pc         (skid_pc_s),
    .instr      (skid_instr_s)
  );

  // Next-state, PC and IF/ID update; a redirect overrides every other path.
  always_comb begin
    accept_s     = !if_valid_r || !id_stall;
    state_n      = state_r;
    pc_n         = pc_r;
    pc_req_n     = pc_req_r;
    if_valid_n   = if_valid_r && id_stall;
    if_pc_n      = if_pc_r;
    if_instr_n   = if_instr_r;
    skid_load_s  = 1'b0;
    skid_clear_s = 1'b0;

    if (redirect_valid) begin
      pc_n         = redirect_pc & ALIGN_MASK;
      if_valid_n   = 1'b0;
      skid_clear_s = 1'b1;
      // A request still in flight must be swallowed before fetching the target.
      if ((state_r == REQ) || ((state_r == WAIT) && !imem_rvalid)) begin
        state_n = DRAIN;
      end else begin
        state_n = REQ;
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_n = REQ;
        end
        REQ: begin
          pc_req_n = pc_r;
          state_n  = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (accept_s) begin
              if_valid_n = 1'b1;
              if_pc_n    = pc_req_r;
              if_instr_n = imem_rdata;
              pc_n       = pc_req_r + PC_STEP;
              state_n    = REQ;
            end else begin
              skid_load_s = 1'b1;
              state_n     = HOLD;
            end
          end else begin
            state_n = WAIT;
          end
        end
        HOLD: begin
          if (accept_s && skid_valid_s) begin
            if_valid_n   = 1'b1;
            if_pc_n      = skid_pc_s;
            if_instr_n   = skid_instr_s;
            pc_n         = skid_pc_s + PC_STEP;
            skid_clear_s = 1'b1;
            state_n      = REQ;
          end else begin
            state_n = HOLD;
          end
        end
        DRAIN: begin
          if (imem_rvalid) begin
            state_n = REQ;
          end else begin
            state_n = DRAIN;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      pc_r       <= RESET_PC;
      pc_req_r   <= {XLEN{1'b0}};
      if_valid_r <= 1'b0;
      if_pc_r    <= {XLEN{1'b0}};
      if_instr_r <= NOP_INSTR;
    end else begin
      state_r    <= state_n;
      pc_r       <= pc_n;
      pc_req_r   <= pc_req_n;
      if_valid_r <= if_valid_n;
      if_pc_r    <= if_pc_n;
      if_instr_r <= if_instr_n;
    end
  end

  assign imem_req  = (state_r == REQ);
  assign imem_addr = pc_r;
  assign if_valid  = if_valid_r;
  assign if_pc     = if_pc_r;
  assign if_instr  = if_instr_r;
  assign if_opcode = opcode_of(if_instr_r);

endmodule
